keypad_entry_sequencer: RTL and testbench
=========================================

// Module: keypad_entry_sequencer
// PURPOSE
//  Upstream front end of the six-digit lock controller. Collects single keypad
//  key presses into a 6-digit entry buffer and supports backspace, cancel and
//  enter. On a valid enter it replays the entry as three digit-pair write strobes,
//  followed by one judge strobe. These drive the controller's pair data
//  (inA/inB), pair-select (y0..y2) and judge (y3) inputs.
// PARAMETERS
//  TIMEOUT_TICKS  10  tick pulses with no accepted key before a partial entry is discarded
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  clr        in   1  asynchronous, active-high reset
//  key_valid  in   1  one-cycle strobe, key_code valid
//  key_code   in   4  0-9 digit, A backspace, B enter, C cancel, D-F invalid
//  tick       in   1  one-cycle timebase enable for timeout (e.g. 1 Hz)
//  lockout    in   1  high = keypad disabled (error-count lockout from controller)
//  pair_a     out  4  first digit of current pair (digit 2p)
//  pair_b     out  4  second digit of current pair (digit 2p+1)
//  wr_sel     out  3  one-hot pair write strobe: 001 digits1-2, 010 3-4, 100 5-6
//  judge      out  1  one-cycle compare strobe after the last pair write
//  busy       out  1  high in WR0..JUDGE; keys ignored
//  count      out  3  digits currently held, 0..6
//  err        out  1  one-cycle pulse on a rejected key
//  timeout    out  1  one-cycle pulse when a partial entry is discarded
// BEHAVIOUR
//  - Reset (clr=1, async): state IDLE, buffer d[0..5]=0, count=0, idle_cnt=0.
//    All outputs are 0. All outputs are registered.
//  - States: IDLE (count=0), ENTRY (1..6), WR0, WR1, WR2, JUDGE.
//  - Key acceptance applies only when key_valid=1, lockout=0 and state is IDLE/ENTRY.
//  - Digit, count<6: d[count]<=code, count+1.
//  - Digit, count=6: ignored, err=1.
//  - Backspace: count-1 if count>0; at 0 ignored with no err. The vacated digit is
//    not cleared.
//  - Cancel: count=0, d=0, return to IDLE, no err.
//  - Enter, count=6: go to WR0.
//  - Enter, count<6: err=1, entry unchanged.
//  - Codes D-F: err=1, ignored.
//  - Write sequence: enter sampled at edge N.
//    - Edges N+1, N+2, N+3 load WR0/WR1/WR2 outputs: wr_sel=1<<p,
//      pair_a=d[2p], pair_b=d[2p+1]. Each holds for exactly one cycle.
//    - Edge N+4 loads JUDGE: judge=1, wr_sel=0, pair_a/b=0.
//    - Edge N+5: judge=0, busy=0, count=0, d=0, state IDLE.
//    - busy=1 from N+1 through N+4. Keys arriving while busy are dropped, no err.
//  - Timeout: idle_cnt increments on tick only in ENTRY with lockout=0.
//    - Cleared by any accepted key, including rejected-with-err keys.
//    - At idle_cnt reaching TIMEOUT_TICKS: clear as cancel, timeout=1 for one cycle.
//    - idle_cnt is held at 0 in IDLE.
//    - key_valid and tick in the same cycle: key processed, idle_cnt<=0.
//  - lockout=1 in IDLE/ENTRY: entry cleared (count=0, d=0), keys ignored silently,
//    idle_cnt held at 0.
//  - lockout rising during WR0..JUDGE: sequence completes unchanged, then the entry
//    clears.
//  - clr asserted mid-sequence: immediate return to reset state; a partial pair
//    write must not be seen after clr.
//  - idle_cnt width is $clog2(TIMEOUT_TICKS+1). count never exceeds 6 or wraps
//    below 0.
// TESTING
//  1. Keys 1,2,3,4,5,6,B
//     -> wr_sel 001/010/100 on 3 consecutive cycles with pairs (1,2),(3,4),(5,6),
//     then judge=1 next cycle, then count=0.
//  2. Keys 7,8,A,9,B
//     -> count 1,2,1,2; enter gives err=1; d[1]=9; no wr_sel activity.
//  3. Keys 1..6 then 7
//     -> err=1, count stays 6.
//     Then E -> err=1. Then C -> count=0, no err.
//  4. Key 3, then 10 ticks idle (TIMEOUT_TICKS=10)
//     -> timeout=1 on the 10th tick edge, count=0.
//     Key and tick in the same cycle -> idle_cnt resets.
//  5. Key 5 then lockout=1
//     -> count=0; keys ignored, no err.
//     Lockout asserted during WR1 -> WR2 and judge still issued.
//  6. clr pulse during WR1
//     -> all outputs 0 asynchronously; no further wr_sel or judge; next keys
//     accepted from IDLE.

Source files
------------

// File: rtl/keypad_entry_sequencer.sv
// Keypad front end for the six-digit lock: buffers digit keys, handles edit/enter/timeout,
// and replays a complete entry as three pair-write strobes followed by one judge strobe.
module keypad_entry_sequencer #(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       tick,
  input  logic       lockout,
  output logic [3:0] pair_a,
  output logic [3:0] pair_b,
  output logic [2:0] wr_sel,
  output logic       judge,
  output logic       busy,
  output logic [2:0] count,
  output logic       err,
  output logic       timeout
);

  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);

  // LAUNCH is the one cycle between sampling enter and the first registered pair write.
  typedef enum logic [2:0] {IDLE, ENTRY, LAUNCH, WR0, WR1, WR2, JUDGE} state_t;

  state_t            state_q, state_nxt;
  logic [3:0]        d_q [6];
  logic [3:0]        d_nxt [6];
  logic [2:0]        count_q, count_nxt;
  logic [IDLE_W-1:0] idle_q, idle_nxt;
  logic              err_nxt, timeout_nxt, judge_nxt, busy_nxt;
  logic [2:0]        wr_sel_nxt;
  logic [3:0]        pair_a_nxt, pair_b_nxt;

  assign count = count_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      count_q <= '0;
      idle_q  <= '0;
      // NOTE: the digit buffer is reset explicitly; cancel and reset must both leave it zeroed.
      d_q     <= '{default: '0};
      pair_a  <= '0;
      pair_b  <= '0;
      wr_sel  <= '0;
      judge   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q <= state_nxt;
      count_q <= count_nxt;
      idle_q  <= idle_nxt;
      d_q     <= d_nxt;
      pair_a  <= pair_a_nxt;
      pair_b  <= pair_b_nxt;
      wr_sel  <= wr_sel_nxt;
      judge   <= judge_nxt;
      busy    <= busy_nxt;
      err     <= err_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_nxt   = state_q;
    count_nxt   = count_q;
    d_nxt       = d_q;
    idle_nxt    = idle_q;
    err_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    case (state_q)
      IDLE, ENTRY: begin
        if (lockout) begin
          state_nxt = IDLE;
          count_nxt = '0;
          d_nxt     = '{default: '0};
          idle_nxt  = '0;
        end else if (key_valid) begin
          idle_nxt = '0;
          if (key_code <= 4'd9) begin
            if (count_q == 3'd6) begin
              err_nxt = 1'b1;
            end else begin
              d_nxt[count_q] = key_code;
              count_nxt      = count_q + 3'd1;
              state_nxt      = ENTRY;
            end
          end else begin
            case (key_code)
              4'hA: if (count_q != 3'd0) begin
                count_nxt = count_q - 3'd1;
                if (count_q == 3'd1) state_nxt = IDLE;
              end
              4'hB: if (count_q == 3'd6) state_nxt = LAUNCH;
                    else err_nxt = 1'b1;
              4'hC: begin
                state_nxt = IDLE;
                count_nxt = '0;
                d_nxt     = '{default: '0};
              end
              default: err_nxt = 1'b1;
            endcase
          end
        end else if (state_q == ENTRY && tick) begin
          if (idle_q == IDLE_W'(TIMEOUT_TICKS - 1)) begin
            state_nxt   = IDLE;
            count_nxt   = '0;
            d_nxt       = '{default: '0};
            idle_nxt    = '0;
            timeout_nxt = 1'b1;
          end else begin
            idle_nxt = idle_q + IDLE_W'(1);
          end
        end
      end
      LAUNCH: state_nxt = WR0;
      WR0:    state_nxt = WR1;
      WR1:    state_nxt = WR2;
      WR2:    state_nxt = JUDGE;
      JUDGE: begin
        state_nxt = IDLE;
        count_nxt = '0;
        d_nxt     = '{default: '0};
        idle_nxt  = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers are loaded from the next state so they line up with state_q.
  always_comb begin
    wr_sel_nxt = 3'b000;
    pair_a_nxt = '0;
    pair_b_nxt = '0;
    judge_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    case (state_nxt)
      WR0: begin
        wr_sel_nxt = 3'b001; pair_a_nxt = d_q[0]; pair_b_nxt = d_q[1]; busy_nxt = 1'b1;
      end
      WR1: begin
        wr_sel_nxt = 3'b010; pair_a_nxt = d_q[2]; pair_b_nxt = d_q[3]; busy_nxt = 1'b1;
      end
      WR2: begin
        wr_sel_nxt = 3'b100; pair_a_nxt = d_q[4]; pair_b_nxt = d_q[5]; busy_nxt = 1'b1;
      end
      JUDGE: begin
        judge_nxt = 1'b1; busy_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Directed bench for keypad_entry_sequencer: entry, editing, rejection, timeout,
// lockout and mid-sequence reset, each scenario checking its own hand-computed results.
module tb_keypad_entry_sequencer;

  logic       clk = 1'b0;
  logic       clr, key_valid, tick, lockout;
  logic [3:0] key_code;
  logic [3:0] pair_a, pair_b;
  logic [2:0] wr_sel, count;
  logic       judge, busy, err, timeout;

  int vectors = 0;
  int miscompares = 0;

  keypad_entry_sequencer #(.TIMEOUT_TICKS(10)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code), .tick(tick),
    .lockout(lockout), .pair_a(pair_a), .pair_b(pair_b), .wr_sel(wr_sel), .judge(judge),
    .busy(busy), .count(count), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: drive on the falling edge, return one falling edge later.
  task automatic press(input logic [3:0] code);
    @(negedge clk); key_valid = 1'b1; key_code = code;
    @(negedge clk); key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; key_valid = 1'b0; key_code = 4'h0; tick = 1'b0; lockout = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({pair_a, pair_b, wr_sel, judge, busy, count, err, timeout} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {pair_a, pair_b, wr_sel, judge, busy, count, err, timeout});
    end
    clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset: count=%0d busy=%b want 0 0", count, busy);
    end
  endtask

  task automatic test_full_entry();
    int dg [6];
    dg = '{1, 2, 3, 4, 5, 6};
    for (int i = 0; i < 6; i++) begin
      press(4'(dg[i]));
      vectors++;
      if (count !== 3'(i + 1)) begin
        miscompares++;
        $display("FAIL entry_count%0d: got %0d want %0d", i, count, i + 1);
      end
    end
    press(4'hB);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0 || wr_sel !== 3'b000) begin
      miscompares++;
      $display("FAIL enter_edge: err=%b busy=%b sel=%b want 0 0 000", err, busy, wr_sel);
    end
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      vectors++;
      if (wr_sel !== 3'(1 << p) || pair_a !== 4'(dg[2*p]) || pair_b !== 4'(dg[2*p+1]) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL wr%0d: sel=%b a=%0d b=%0d busy=%b want sel=%b a=%0d b=%0d busy=1",
                 p, wr_sel, pair_a, pair_b, busy, 3'(1 << p), dg[2*p], dg[2*p+1]);
      end
    end
    @(negedge clk);
    vectors++;
    if (judge !== 1'b1 || wr_sel !== 3'b000 || pair_a !== 4'd0 || pair_b !== 4'd0 || busy !== 1'b1 || count !== 3'd6) begin
      miscompares++;
      $display("FAIL judge: judge=%b sel=%b a=%0d b=%0d busy=%b count=%0d want 1 000 0 0 1 6",
               judge, wr_sel, pair_a, pair_b, busy, count);
    end
    @(negedge clk);
    vectors++;
    if (judge !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL seq_done: judge=%b busy=%b count=%0d want 0 0 0", judge, busy, count);
    end
  endtask

  task automatic test_backspace();
    logic [2:0] exp_cnt [4];
    logic [3:0] keys [4];
    int dg [6];
    logic quiet;
    exp_cnt = '{3'd1, 3'd2, 3'd1, 3'd2};
    keys    = '{4'h7, 4'h8, 4'hA, 4'h9};
    dg      = '{7, 9, 1, 2, 3, 4};
    for (int i = 0; i < 4; i++) begin
      press(keys[i]);
      vectors++;
      if (count !== exp_cnt[i] || err !== 1'b0) begin
        miscompares++;
        $display("FAIL bs_count%0d: count=%0d err=%b want %0d 0", i, count, err, exp_cnt[i]);
      end
    end
    press(4'hB);
    vectors++;
    if (err !== 1'b1 || count !== 3'd2) begin
      miscompares++;
      $display("FAIL short_enter: err=%b count=%0d want 1 2", err, count);
    end
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (wr_sel !== 3'b000 || busy !== 1'b0 || judge !== 1'b0 || err !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (quiet !== 1'b1) begin
      miscompares++;
      $display("FAIL short_enter_quiet: activity seen, want none");
    end
    for (int i = 2; i < 6; i++) press(4'(dg[i]));
    press(4'hB);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      vectors++;
      if (wr_sel !== 3'(1 << p) || pair_a !== 4'(dg[2*p]) || pair_b !== 4'(dg[2*p+1])) begin
        miscompares++;
        $display("FAIL bs_wr%0d: sel=%b a=%0d b=%0d want sel=%b a=%0d b=%0d",
                 p, wr_sel, pair_a, pair_b, 3'(1 << p), dg[2*p], dg[2*p+1]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) press(4'(i));
    press(4'h7);
    vectors++;
    if (err !== 1'b1 || count !== 3'd6) begin
      miscompares++;
      $display("FAIL overflow: err=%b count=%0d want 1 6", err, count);
    end
    press(4'hE);
    vectors++;
    if (err !== 1'b1 || count !== 3'd6) begin
      miscompares++;
      $display("FAIL invalid_code: err=%b count=%0d want 1 6", err, count);
    end
    press(4'hC);
    vectors++;
    if (err !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL cancel: err=%b count=%0d want 0 0", err, count);
    end
    press(4'hA);
    vectors++;
    if (err !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL bs_at_zero: err=%b count=%0d want 0 0", err, count);
    end
    press(4'hB);
    vectors++;
    if (err !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL enter_at_zero: err=%b count=%0d want 1 0", err, count);
    end
  endtask

  task automatic test_timeout();
    press(4'h3);
    repeat (9) pulse_tick();
    vectors++;
    if (timeout !== 1'b0 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL pre_timeout: timeout=%b count=%0d want 0 1", timeout, count);
    end
    pulse_tick();
    vectors++;
    if (timeout !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL timeout: timeout=%b count=%0d want 1 0", timeout, count);
    end
    @(negedge clk);
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: timeout=%b want 0", timeout);
    end
    // Ticks while idle must not pre-load the counter.
    repeat (5) pulse_tick();
    press(4'h3);
    repeat (5) pulse_tick();
    @(negedge clk); key_valid = 1'b1; key_code = 4'h4; tick = 1'b1;
    @(negedge clk); key_valid = 1'b0; key_code = 4'h0; tick = 1'b0;
    repeat (9) pulse_tick();
    vectors++;
    if (timeout !== 1'b0 || count !== 3'd2) begin
      miscompares++;
      $display("FAIL key_tick_restart: timeout=%b count=%0d want 0 2", timeout, count);
    end
    pulse_tick();
    vectors++;
    if (timeout !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL timeout_after_restart: timeout=%b count=%0d want 1 0", timeout, count);
    end
  endtask

  task automatic test_lockout();
    press(4'h5);
    @(negedge clk); lockout = 1'b1;
    @(negedge clk);
    vectors++;
    if (count !== 3'd0) begin
      miscompares++;
      $display("FAIL lockout_clear: count=%0d want 0", count);
    end
    press(4'h7);
    vectors++;
    if (count !== 3'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL lockout_ignore: count=%0d err=%b want 0 0", count, err);
    end
    lockout = 1'b0;
    for (int i = 1; i <= 6; i++) press(4'(i));
    press(4'hB);
    repeat (2) @(negedge clk);
    lockout = 1'b1;
    @(negedge clk);
    vectors++;
    if (wr_sel !== 3'b100 || pair_a !== 4'd5 || pair_b !== 4'd6) begin
      miscompares++;
      $display("FAIL lockout_wr2: sel=%b a=%0d b=%0d want 100 5 6", wr_sel, pair_a, pair_b);
    end
    @(negedge clk);
    vectors++;
    if (judge !== 1'b1) begin
      miscompares++;
      $display("FAIL lockout_judge: judge=%b want 1", judge);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL lockout_end: busy=%b count=%0d want 0 0", busy, count);
    end
    lockout = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clr_mid_sequence();
    logic quiet;
    for (int i = 1; i <= 6; i++) press(4'(i));
    press(4'hB);
    repeat (2) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    vectors++;
    if ({pair_a, pair_b, wr_sel, judge, busy, count, err, timeout} !== 18'd0) begin
      miscompares++;
      $display("FAIL clr_async: got %h want 0", {pair_a, pair_b, wr_sel, judge, busy, count, err, timeout});
    end
    @(negedge clk); clr = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (wr_sel !== 3'b000 || judge !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (quiet !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_no_resume: write or judge seen after clr");
    end
    press(4'h4);
    vectors++;
    if (count !== 3'd1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_reentry: count=%0d err=%b want 1 0", count, err);
    end
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_backspace();
    test_overflow();
    test_timeout();
    test_lockout();
    test_clr_mid_sequence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
